shift_arbiter: RTL

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter_if.sv | 35 +++
 rtl/shift_arbiter.sv | 68 ++++++
 2 files changed

// File: rtl/shift_arbiter_if.sv
// rtl/shift_arbiter_if.sv - two-requester shift arbiter bus bundle
interface shift_arbiter_if;
    logic        req0;
    logic [15:0] in0;
    logic [3:0]  cnt0;
    logic [1:0]  op0;
    logic        req1;
    logic [15:0] in1;
    logic [3:0]  cnt1;
    logic [1:0]  op1;
    logic [15:0] sh_in;
    logic [3:0]  sh_cnt;
    logic [1:0]  sh_op;
    logic [15:0] sh_out;
    logic        done0;
    logic        done1;
    logic [15:0] result;
    logic        busy;

    modport slave (
        input  req0, in0, cnt0, op0,
        input  req1, in1, cnt1, op1,
        input  sh_out,
        output sh_in, sh_cnt, sh_op,
        output done0, done1, result, busy
    );

    modport master (
        output req0, in0, cnt0, op0,
        output req1, in1, cnt1, op1,
        output sh_out,
        input  sh_in, sh_cnt, sh_op,
        input  done0, done1, result, busy
    );
endinterface

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - arbitrates two requesters onto one external shifter
module shift_arbiter #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    shift_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        ptr;
    logic        gnt;
    logic        take;
    logic        win1;
    logic [15:0] opnd_in;
    logic [3:0]  opnd_cnt;
    logic [1:0]  opnd_op;
    logic [15:0] res;

    // Requester 1 wins when alone, or on a tie when round-robin points at it.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        win1      = 1'b0;
        case (state)
            IDLE: begin
                take = bus.req0 | bus.req1;
                win1 = bus.req1 & (~bus.req0 | (~FIXED_PRI & ptr));
                if (take) state_nxt = EXEC;
            end
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            gnt      <= 1'b0;
            opnd_in  <= 16'h0000;
            opnd_cnt <= 4'h0;
            opnd_op  <= 2'b00;
            res      <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (take) begin
                gnt      <= win1;
                ptr      <= ~win1;
                opnd_in  <= win1 ? bus.in1  : bus.in0;
                opnd_cnt <= win1 ? bus.cnt1 : bus.cnt0;
                opnd_op  <= win1 ? bus.op1  : bus.op0;
            end
            if (state == EXEC) res <= bus.sh_out;
        end
    end

    assign bus.sh_in  = (state == EXEC) ? opnd_in  : 16'h0000;
    assign bus.sh_cnt = (state == EXEC) ? opnd_cnt : 4'h0;
    assign bus.sh_op  = (state == EXEC) ? opnd_op  : 2'b00;
    assign bus.done0  = (state == DONE) & ~gnt;
    assign bus.done1  = (state == DONE) &  gnt;
    assign bus.busy   = (state != IDLE);
    assign bus.result = res;
endmodule
